// File: rtl/stage0_redirect_monitor.sv
// Stage0 redirect monitor: classifies fetch redirects, flushes and
// fences into timestamped records queued for the bench scoreboard.
//
// Ports:
//   CLK, RST          core clock; synchronous active-high reset
//   mon_en            enables classification, push and epoch check
//   rg_pc*            stage0 PC, next PC and update strobe probes
//   rg_eEpoch/wEpoch  execute / writeback epoch probes
//   ma_flush_fl       flush request into stage0
//   rg_fence/sfence   fence / sfence pending probes
//   rec_valid/ready   record FIFO head handshake
//   rec_data          {type,eEpoch,wEpoch,pc_from,pc_to,ts}
//   drop_cnt          records lost on a full FIFO (saturating)
//   err_epoch/err_cnt epoch-without-flush flag and count
module stage0_redirect_monitor #(
    parameter int XLEN       = 64,
    parameter int FETCH_STEP = 4,
    parameter int DEPTH      = 16,
    parameter int TS_W       = 32
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       mon_en,
    input  logic [XLEN-1:0]            rg_pc,
    input  logic [XLEN-1:0]            rg_pc_D_IN,
    input  logic                       rg_pc_EN,
    input  logic                       rg_eEpoch,
    input  logic                       rg_wEpoch,
    input  logic                       ma_flush_fl,
    input  logic                       rg_fence,
    input  logic                       rg_sfence,
    output logic                       rec_valid,
    input  logic                       rec_ready,
    output logic [4+2*XLEN+TS_W-1:0]   rec_data,
    output logic [15:0]                drop_cnt,
    output logic                       err_epoch,
    output logic [7:0]                 err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = 4 + 2*XLEN + TS_W;

    typedef enum logic [1:0] {
        REC_NONE  = 2'd0,
        REC_FLUSH = 2'd1,
        REC_FENCE = 2'd2,
        REC_JUMP  = 2'd3
    } rec_type_e;

    // ------------------------------------------------------------
    // Timestamp and previous-cycle samples
    // ------------------------------------------------------------
    logic [TS_W-1:0] ts;
    logic            prev_e;
    logic            prev_w;
    logic            prev_fs;
    logic            prev_flush;
    logic            prime;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ts         <= '0;
            prev_e     <= 1'b0;
            prev_w     <= 1'b0;
            prev_fs    <= 1'b0;
            prev_flush <= 1'b0;
            prime      <= 1'b0;
        end else begin
            ts         <= ts + TS_W'(1);
            prev_e     <= rg_eEpoch;
            prev_w     <= rg_wEpoch;
            prev_fs    <= rg_fence | rg_sfence;
            prev_flush <= ma_flush_fl;
            // Check is armed only after a full enabled cycle, so a
            // re-enable never compares against stale disabled samples.
            prime      <= mon_en;
        end
    end

    // ------------------------------------------------------------
    // Classification
    // ------------------------------------------------------------
    logic            fence_rise;
    logic            is_jump;
    logic [XLEN-1:0] pc_seq;
    rec_type_e       rec_type;
    logic [XLEN-1:0] pc_from;
    logic [XLEN-1:0] pc_to;
    logic            rec_push;
    logic [RW-1:0]   rec_d;

    assign pc_seq     = rg_pc + XLEN'(FETCH_STEP);
    assign fence_rise = (rg_fence | rg_sfence) & ~prev_fs;
    assign is_jump    = rg_pc_EN & (rg_pc_D_IN != pc_seq);

    // Several events may coincide; the first match wins.
    always_comb begin
        rec_type = REC_NONE;
        pc_from  = rg_pc;
        pc_to    = rg_pc;
        priority case (1'b1)
            ma_flush_fl: begin
                rec_type = REC_FLUSH;
                pc_to    = rg_pc_EN ? rg_pc_D_IN : rg_pc;
            end
            fence_rise: begin
                rec_type = REC_FENCE;
            end
            is_jump: begin
                rec_type = REC_JUMP;
                pc_to    = rg_pc_D_IN;
            end
            default: begin
                rec_type = REC_NONE;
            end
        endcase
    end

    assign rec_push = mon_en & (rec_type != REC_NONE);
    assign rec_d    = {rec_type, rg_eEpoch, rg_wEpoch,
                       pc_from, pc_to, ts};

    // ------------------------------------------------------------
    // Record FIFO (first-word-fall-through, registered storage)
    // ------------------------------------------------------------
    logic [RW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full_q;
    logic          empty;
    logic          do_pop;
    logic          do_push;
    logic          do_drop;
    logic          wr_hits_rd;

    // Equal pointers are ambiguous; full_q tells full from empty.
    assign empty      = (wr_ptr == rd_ptr) & ~full_q;
    assign rec_valid  = ~empty;
    assign do_pop     = rec_valid & rec_ready;
    assign do_push    = rec_push & (~full_q | do_pop);
    assign do_drop    = rec_push & full_q & ~do_pop;
    assign wr_hits_rd = (wr_ptr + AW'(1)) == rd_ptr;

    assign rec_data = rec_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (!RST && do_push) begin
            mem[wr_ptr] <= rec_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop && wr_hits_rd) begin
                full_q <= 1'b1;
            end else if (do_pop && !do_push) begin
                full_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            drop_cnt <= '0;
        end else if (do_drop && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------
    // Epoch check: an epoch change must be covered by a flush in
    // the same or the previous cycle.
    // ------------------------------------------------------------
    logic ep_change;
    logic ep_bad;

    assign ep_change = (rg_eEpoch != prev_e) | (rg_wEpoch != prev_w);
    assign ep_bad    = mon_en & prime & ep_change
                     & ~(ma_flush_fl | prev_flush);

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_epoch <= 1'b0;
            err_cnt   <= '0;
        end else if (ep_bad) begin
            err_epoch <= 1'b1;
            if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_stage0_redirect_monitor.sv
// Directed bench for stage0_redirect_monitor.
// Default parameters: XLEN=64, DEPTH=16, TS_W=32.
module tb_stage0_redirect_monitor;

    logic          CLK;
    logic          RST;
    logic          mon_en;
    logic [63:0]   rg_pc;
    logic [63:0]   rg_pc_D_IN;
    logic          rg_pc_EN;
    logic          rg_eEpoch;
    logic          rg_wEpoch;
    logic          ma_flush_fl;
    logic          rg_fence;
    logic          rg_sfence;
    logic          rec_valid;
    logic          rec_ready;
    logic [163:0]  rec_data;
    logic [15:0]   drop_cnt;
    logic          err_epoch;
    logic [7:0]    err_cnt;

    int total;
    int bad;
    int cyc;
    logic [163:0] exp_q [19];

    stage0_redirect_monitor dut (
        .CLK         (CLK),
        .RST         (RST),
        .mon_en      (mon_en),
        .rg_pc       (rg_pc),
        .rg_pc_D_IN  (rg_pc_D_IN),
        .rg_pc_EN    (rg_pc_EN),
        .rg_eEpoch   (rg_eEpoch),
        .rg_wEpoch   (rg_wEpoch),
        .ma_flush_fl (ma_flush_fl),
        .rg_fence    (rg_fence),
        .rg_sfence   (rg_sfence),
        .rec_valid   (rec_valid),
        .rec_ready   (rec_ready),
        .rec_data    (rec_data),
        .drop_cnt    (drop_cnt),
        .err_epoch   (err_epoch),
        .err_cnt     (err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag,
                       input logic [255:0] got,
                       input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock; cyc mirrors the timestamp the DUT holds afterwards.
    task automatic step();
        @(posedge CLK);
        if (RST) cyc = 0;
        else     cyc = cyc + 1;
        #1;
    endtask

    function automatic logic [163:0] mk(input logic [1:0]  t,
                                        input logic        e,
                                        input logic        w,
                                        input logic [63:0] f,
                                        input logic [63:0] to,
                                        input int          ts);
        logic [31:0] ts32;
        ts32 = ts[31:0];
        return {t, e, w, f, to, ts32};
    endfunction

    initial begin
        logic [163:0] e;
        total       = 0;
        bad         = 0;
        cyc         = 0;
        RST         = 1'b1;
        mon_en      = 1'b1;
        rg_pc       = '0;
        rg_pc_D_IN  = '0;
        rg_pc_EN    = 1'b0;
        rg_eEpoch   = 1'b0;
        rg_wEpoch   = 1'b0;
        ma_flush_fl = 1'b0;
        rg_fence    = 1'b0;
        rg_sfence   = 1'b0;
        rec_ready   = 1'b0;

        // 1. reset state
        repeat (3) step();
        chk("rst_valid", 256'(rec_valid), 256'(0));
        chk("rst_data", 256'(rec_data), 256'(0));
        chk("rst_drop", 256'(drop_cnt), 256'(0));
        chk("rst_err", 256'(err_epoch), 256'(0));
        chk("rst_errcnt", 256'(err_cnt), 256'(0));
        RST = 1'b0;
        step();
        step();
        chk("idle_valid", 256'(rec_valid), 256'(0));

        // 2. sequential updates produce nothing
        rg_pc      = 64'h8000_0000;
        rg_pc_D_IN = 64'h8000_0004;
        rg_pc_EN   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("seq_valid", 256'(rec_valid), 256'(0));
        end
        rg_pc_EN = 1'b0;

        // 3. single jump at ts=20
        while (cyc < 20) step();
        rg_pc      = 64'h8000_0010;
        rg_pc_D_IN = 64'h8000_0100;
        rg_pc_EN   = 1'b1;
        rec_ready  = 1'b1;
        step();
        rg_pc_EN = 1'b0;
        chk("jmp_valid", 256'(rec_valid), 256'(1));
        chk("jmp_type", 256'(rec_data[163:162]), 256'(3));
        chk("jmp_from", 256'(rec_data[159:96]), 256'(64'h8000_0010));
        chk("jmp_to", 256'(rec_data[95:32]), 256'(64'h8000_0100));
        chk("jmp_ts", 256'(rec_data[31:0]), 256'(20));
        step();
        chk("jmp_popped", 256'(rec_valid), 256'(0));

        // 4. flush + fence together, covered epoch toggle
        rec_ready   = 1'b0;
        rg_pc       = 64'h8000_0200;
        ma_flush_fl = 1'b1;
        rg_fence    = 1'b1;
        e = mk(2'd1, 1'b0, 1'b0, 64'h8000_0200, 64'h8000_0200, cyc);
        step();
        chk("fl_valid", 256'(rec_valid), 256'(1));
        chk("fl_data", 256'(rec_data), 256'(e));
        ma_flush_fl = 1'b0;
        rg_eEpoch   = 1'b1;
        step();
        chk("fl_err", 256'(err_epoch), 256'(0));
        chk("fl_errcnt", 256'(err_cnt), 256'(0));
        rec_ready = 1'b1;
        step();
        chk("fl_single", 256'(rec_valid), 256'(0));
        rec_ready = 1'b0;
        rg_fence  = 1'b0;
        rg_wEpoch = 1'b1;
        step();
        chk("ep_err", 256'(err_epoch), 256'(1));
        chk("ep_errcnt", 256'(err_cnt), 256'(1));
        chk("ep_norec", 256'(rec_valid), 256'(0));

        // monitor disabled, then unchecked first cycle after re-enable
        mon_en     = 1'b0;
        rg_pc_D_IN = 64'h8000_0240;
        rg_pc_EN   = 1'b1;
        step();
        chk("dis_norec", 256'(rec_valid), 256'(0));
        mon_en    = 1'b1;
        rg_pc_EN  = 1'b0;
        rg_eEpoch = 1'b0;
        step();
        chk("reen_errcnt", 256'(err_cnt), 256'(1));

        // 5. fill with 18 jumps, two dropped
        for (int i = 0; i < 18; i++) begin
            rg_pc      = 64'h1000 + 64'(i) * 64'h100;
            rg_pc_D_IN = rg_pc + 64'h40;
            rg_pc_EN   = 1'b1;
            exp_q[i] = mk(2'd3, rg_eEpoch, rg_wEpoch,
                          rg_pc, rg_pc_D_IN, cyc);
            step();
        end
        chk("full_drop", 256'(drop_cnt), 256'(2));
        chk("full_head", 256'(rec_data), 256'(exp_q[0]));

        // 6. push and pop while full
        rg_pc      = 64'h9000;
        rg_pc_D_IN = 64'h9400;
        rec_ready  = 1'b1;
        exp_q[18] = mk(2'd3, rg_eEpoch, rg_wEpoch,
                       rg_pc, rg_pc_D_IN, cyc);
        step();
        rg_pc_EN = 1'b0;
        chk("pp_drop", 256'(drop_cnt), 256'(2));
        for (int k = 0; k < 16; k++) begin
            chk("drain_valid", 256'(rec_valid), 256'(1));
            chk("drain_data", 256'(rec_data),
                256'(exp_q[k < 15 ? k + 1 : 18]));
            step();
        end
        chk("drain_empty", 256'(rec_valid), 256'(0));

        // refill, then reset mid-drain
        rec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rg_pc      = 64'h2000 + 64'(i) * 64'h100;
            rg_pc_D_IN = rg_pc + 64'h80;
            rg_pc_EN   = 1'b1;
            step();
        end
        rg_pc_EN  = 1'b0;
        rec_ready = 1'b1;
        step();
        chk("mid_valid", 256'(rec_valid), 256'(1));
        chk("mid_drop", 256'(drop_cnt), 256'(2));
        RST = 1'b1;
        step();
        chk("mrst_valid", 256'(rec_valid), 256'(0));
        chk("mrst_drop", 256'(drop_cnt), 256'(0));
        chk("mrst_err", 256'(err_epoch), 256'(0));
        chk("mrst_errcnt", 256'(err_cnt), 256'(0));
        RST = 1'b0;
        step();
        chk("post_valid", 256'(rec_valid), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
